instr_encoder: RTL and testbench

- Builds RV32I instruction words from decoded fields, the inverse of the ID-stage immediate extension.
- Fed by the boot/debug instruction-injection path; drives the instruction-memory write port or the IF injection mux.
- Packs immediates into the R/I/S/B/U/J bit layouts and checks their range.
- Expands the LI pseudo-op into LUI and/or ADDI.
- Uses valid/ready handshakes on both sides, with a registered output stage.

---
 rtl/instr_enc_pkg.sv | 25 ++
 rtl/instr_encoder_imm_packer.sv | 66 ++++++
 rtl/instr_encoder.sv | 145 ++++++++++++++
 tb/tb_instr_encoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_enc_pkg.sv
// Shared types for the RV32I instruction encoder.
// Format codes, opcodes used by LI expansion, and FSM states.
package instr_enc_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_LI  = 3'd6,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_OPIMM = 7'b0010011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_HOLD_HI
  } state_e;

endpackage

// File: rtl/instr_encoder_imm_packer.sv
// Combinational RV32I field packer with immediate range check.
// Out-of-range immediates are truncated into the word and flagged.
module imm_packer
  import instr_enc_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  fmt_e        fmt_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic [6:0]  funct7_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] instr_o,
  output logic        err_o
);

  logic fit12;
  logic fit13;
  logic fit21;

  assign fit12 = (&imm_i[31:11]) | ~(|imm_i[31:11]);
  assign fit13 = (&imm_i[31:12]) | ~(|imm_i[31:12]);
  assign fit21 = (&imm_i[31:20]) | ~(|imm_i[31:20]);

  always_comb begin
    instr_o = NOP_WORD;
    err_o   = 1'b0;
    unique case (fmt_i)
      FMT_R: instr_o = {funct7_i, rs2_i, rs1_i,
                        funct3_i, rd_i, opcode_i};
      FMT_I: begin
        instr_o = {imm_i[11:0], rs1_i,
                   funct3_i, rd_i, opcode_i};
        err_o   = ~fit12;
      end
      FMT_S: begin
        instr_o = {imm_i[11:5], rs2_i, rs1_i,
                   funct3_i, imm_i[4:0], opcode_i};
        err_o   = ~fit12;
      end
      FMT_B: begin
        instr_o = {imm_i[12], imm_i[10:5], rs2_i, rs1_i,
                   funct3_i, imm_i[4:1], imm_i[11],
                   opcode_i};
        err_o   = imm_i[0] | ~fit13;
      end
      FMT_U: begin
        instr_o = {imm_i[31:12], rd_i, opcode_i};
        err_o   = |imm_i[11:0];
      end
      FMT_J: begin
        instr_o = {imm_i[20], imm_i[10:1], imm_i[11],
                   imm_i[19:12], rd_i, opcode_i};
        err_o   = imm_i[0] | ~fit21;
      end
      default: begin
        instr_o = NOP_WORD;
        err_o   = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder with LI expansion.
// Registered output stage; valid/ready on request and output.
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_fmt,
  input  logic [6:0]  req_opcode,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic        out_err,
  output logic        out_last
);

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic        err_q, err_d;
  logic        last_q, last_d;
  logic [31:0] pend_q, pend_d;

  fmt_e        fmt;
  fmt_e        p_fmt;
  logic [6:0]  p_op;
  logic [2:0]  p_f3;
  logic [4:0]  p_rs1;
  logic [31:0] p_imm;
  logic [31:0] p_instr;
  logic        p_err;

  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic        li_two;
  logic [31:0] li_addi;
  logic        accept;
  logic        hs;

  assign fmt   = fmt_e'(req_fmt);
  // +0x800 rounding only carries out of the low 12 bits when bit 11 is set
  assign li_hi = req_imm[31:12] + {19'd0, req_imm[11]};
  assign li_lo = req_imm[11:0];
  assign li_addi = {li_lo, req_rd, 3'b000, req_rd, OP_OPIMM};

  always_comb begin
    p_fmt  = fmt;
    p_op   = req_opcode;
    p_f3   = req_funct3;
    p_rs1  = req_rs1;
    p_imm  = req_imm;
    li_two = 1'b0;
    if (fmt == FMT_LI) begin
      if (li_hi == 20'd0) begin
        p_fmt = FMT_I;
        p_op  = OP_OPIMM;
        p_f3  = 3'd0;
        p_rs1 = 5'd0;
        p_imm = {{20{li_lo[11]}}, li_lo};
      end else begin
        p_fmt  = FMT_U;
        p_op   = OP_LUI;
        p_imm  = {li_hi, 12'd0};
        li_two = |li_lo;
      end
    end
  end

  imm_packer #(
    .NOP_WORD (NOP_WORD)
  ) u_pack (
    .fmt_i    (p_fmt),
    .opcode_i (p_op),
    .funct3_i (p_f3),
    .funct7_i (req_funct7),
    .rd_i     (req_rd),
    .rs1_i    (p_rs1),
    .rs2_i    (req_rs2),
    .imm_i    (p_imm),
    .instr_o  (p_instr),
    .err_o    (p_err)
  );

  assign out_valid = (state_q != S_IDLE);
  assign req_ready = (state_q == S_IDLE) |
                     ((state_q == S_HOLD) & out_ready);
  assign accept    = req_valid & req_ready;
  assign hs        = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    err_d   = err_q;
    last_d  = last_q;
    pend_d  = pend_q;
    unique case (state_q)
      S_IDLE: ;
      S_HOLD: if (hs) state_d = S_IDLE;
      S_HOLD_HI: if (hs) begin
        instr_d = pend_q;
        err_d   = 1'b0;
        last_d  = 1'b1;
        state_d = S_HOLD;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      instr_d = p_instr;
      err_d   = p_err;
      last_d  = ~li_two;
      pend_d  = li_addi;
      state_d = li_two ? S_HOLD_HI : S_HOLD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      instr_q <= 32'd0;
      err_q   <= 1'b0;
      last_q  <= 1'b0;
      pend_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      err_q   <= err_d;
      last_q  <= last_d;
      pend_q  <= pend_d;
    end
  end

  assign out_instr = instr_q;
  assign out_err   = err_q;
  assign out_last  = last_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed-vector bench for instr_encoder.
// Inputs change on negedge; outputs sampled on negedge.
module tb_instr_encoder;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;
  logic        out_last;

  int n_tests;
  int n_fail;

  instr_encoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_fmt    (req_fmt),
    .req_opcode (req_opcode),
    .req_funct3 (req_funct3),
    .req_funct7 (req_funct7),
    .req_rd     (req_rd),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_imm    (req_imm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_instr  (out_instr),
    .out_err    (out_err),
    .out_last   (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h",
               tag, got, exp);
    end
  endtask

  task automatic set_req(input logic [2:0] f,
                         input logic [6:0] op,
                         input logic [2:0] f3,
                         input logic [6:0] f7,
                         input logic [4:0] rd,
                         input logic [4:0] rs1,
                         input logic [4:0] rs2,
                         input logic [31:0] imm);
    req_fmt    = f;
    req_opcode = op;
    req_funct3 = f3;
    req_funct7 = f7;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_imm    = imm;
    req_valid  = 1'b1;
  endtask

  // Call on a negedge; returns on the negedge after acceptance.
  task automatic send(input logic [2:0] f,
                      input logic [6:0] op,
                      input logic [2:0] f3,
                      input logic [6:0] f7,
                      input logic [4:0] rd,
                      input logic [4:0] rs1,
                      input logic [4:0] rs2,
                      input logic [31:0] imm);
    int n;
    set_req(f, op, f3, f7, rd, rs1, rs2, imm);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic word(input string tag,
                      input logic [31:0] ins,
                      input logic err,
                      input logic last);
    chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, ".instr"}, out_instr, ins);
    chk({tag, ".err"}, {31'd0, out_err}, {31'd0, err});
    chk({tag, ".last"}, {31'd0, out_last}, {31'd0, last});
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    out_ready = 1'b1;
    req_valid = 1'b0;
    set_req(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    req_valid = 1'b0;
    #12;
    chk("rst.valid", {31'd0, out_valid}, 32'd0);
    chk("rst.instr", out_instr, 32'd0);
    chk("rst.err", {31'd0, out_err}, 32'd0);
    chk("rst.last", {31'd0, out_last}, 32'd0);
    chk("rst.ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd6, 5'd0, 32'hFFFF_FFFF);
    word("addi", 32'hFFF30293, 1'b0, 1'b1);
    @(negedge clk);
    chk("addi.drain", {31'd0, out_valid}, 32'd0);

    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8);
    word("beq8", 32'h00208463, 1'b0, 1'b1);
    @(negedge clk);
    send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd7);
    chk("beq7.err", {31'd0, out_err}, 32'd1);
    @(negedge clk);
    send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
    word("jal", 32'h001000EF, 1'b0, 1'b1);
    @(negedge clk);
    send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd3, 5'd2, 32'hFFFF_FFFC);
    word("sw", 32'hFE21AE23, 1'b0, 1'b1);
    @(negedge clk);
    send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    word("add", 32'h002081B3, 1'b0, 1'b1);
    @(negedge clk);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'hABCDE000);
    word("lui", 32'hABCDE537, 1'b0, 1'b1);
    @(negedge clk);
    send(3'd4, 7'h37, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'hABCDE001);
    word("lui_bad", 32'hABCDE537, 1'b1, 1'b1);
    @(negedge clk);
    send(3'd1, 7'h13, 3'd0, 7'd0, 5'd5, 5'd6, 5'd0, 32'h0000_0800);
    word("addi_rng", 32'h80030293, 1'b1, 1'b1);
    @(negedge clk);
    send(3'd7, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0);
    word("ill", 32'h00000013, 1'b1, 1'b1);
    @(negedge clk);

    send(3'd6, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345FFF);
    word("li1.lui", 32'h123460B7, 1'b0, 1'b0);
    @(negedge clk);
    word("li1.addi", 32'hFFF08093, 1'b0, 1'b1);
    @(negedge clk);
    chk("li1.drain", {31'd0, out_valid}, 32'd0);
    send(3'd6, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
    word("li_small", 32'h00500093, 1'b0, 1'b1);
    @(negedge clk);
    send(3'd6, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h12345000);
    word("li_hi", 32'h123450B7, 1'b0, 1'b1);
    @(negedge clk);

    out_ready = 1'b0;
    send(3'd6, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    for (int i = 0; i < 3; i++) begin
      word("bp.lui", 32'h000010B7, 1'b0, 1'b0);
      chk("bp.ready", {31'd0, req_ready}, 32'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    word("bp.lui_hs", 32'h000010B7, 1'b0, 1'b0);
    @(negedge clk);
    word("bp.addi", 32'h80008093, 1'b0, 1'b1);
    @(negedge clk);
    chk("bp.drain", {31'd0, out_valid}, 32'd0);

    set_req(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1);
    @(negedge clk);
    for (int i = 2; i <= 4; i++) begin
      chk("b2b.ready", {31'd0, req_ready}, 32'd1);
      word("b2b", {12'(i - 1), 20'h00093}, 1'b0, 1'b1);
      req_imm = 32'(i);
      @(negedge clk);
    end
    req_valid = 1'b0;
    word("b2b.tail", 32'h00400093, 1'b0, 1'b1);
    @(negedge clk);
    chk("b2b.drain", {31'd0, out_valid}, 32'd0);

    out_ready = 1'b0;
    send(3'd6, 7'd0, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800);
    word("rst.hold_hi", 32'h000010B7, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'd0, out_valid}, 32'd0);
    chk("arst.instr", out_instr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst.valid", {31'd0, out_valid}, 32'd0);
      chk("post_rst.ready", {31'd0, req_ready}, 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
